// File: rtl/circle_rasterizer_if.sv
`default_nettype none
// ============================================================================
// Module   : circle_rasterizer_if
// Purpose  : Command and pixel-stream bundle between a circle rasterizer and
//            its controller / framebuffer write port.
// Revision : 1.0 - initial release
// ============================================================================
interface circle_rasterizer_if #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int RW = 9
);
    logic          start;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [RW-1:0] r;
    logic          busy;
    logic          done;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_ready;

    // master: the rasterizer, which sources the pixel stream
    modport master (
        input  start, cx, cy, r, pix_ready,
        output busy, done, pix_valid, pix_x, pix_y
    );

    modport slave (
        output start, cx, cy, r, pix_ready,
        input  busy, done, pix_valid, pix_x, pix_y
    );
endinterface
`default_nettype wire

// File: rtl/circle_rasterizer.sv
`default_nettype none
// ============================================================================
// Module   : circle_rasterizer
// Purpose  : Midpoint circle generator emitting 8 clipped symmetric pixels per
//            octant step over a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module circle_rasterizer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int RW    = 9
) (
    input  logic                clk,
    input  logic                rst,
    circle_rasterizer_if.master bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_plot = 2'd1;
    localparam logic [1:0] c_st_step = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam int c_dw = RW + 4;

    localparam logic signed [c_dw-1:0] c_d_zero  = '0;
    localparam logic signed [c_dw-1:0] c_d_three = c_dw'(3);
    localparam logic signed [c_dw-1:0] c_d_six   = c_dw'(6);
    localparam logic signed [c_dw-1:0] c_d_ten   = c_dw'(10);
    localparam logic signed [RW+1:0]   c_one_s   = (RW+2)'(1);
    localparam logic signed [XW+1:0]   c_h_lim   = (XW+2)'(H_RES);
    localparam logic signed [YW+1:0]   c_v_lim   = (YW+2)'(V_RES);

    logic [1:0]               r_state;
    logic [XW-1:0]            r_cx;
    logic [YW-1:0]            r_cy;
    logic [RW:0]              r_x;
    logic [RW:0]              r_y;
    logic signed [c_dw-1:0]   r_d;
    logic [2:0]               r_oct;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pix_valid;
    logic [XW-1:0]            r_pix_x;
    logic [YW-1:0]            r_pix_y;

    // ---------------------------------------------------------------- step math
    logic signed [c_dw-1:0] w_x_d;
    logic signed [c_dw-1:0] w_y_d;
    logic signed [c_dw-1:0] w_d_next;
    logic signed [c_dw-1:0] w_d_init;
    logic signed [RW+1:0]   w_x_next_s;
    logic signed [RW+1:0]   w_y_next_s;
    logic [RW:0]            w_x_next;
    logic [RW:0]            w_y_next;
    logic                   w_continue;

    always_comb begin
        w_x_d      = signed'(c_dw'(r_x));
        w_y_d      = signed'(c_dw'(r_y));
        w_d_init   = c_d_three - (signed'(c_dw'(bus.r)) <<< 1);
        w_x_next_s = signed'({1'b0, r_x}) + c_one_s;
        if (r_d > c_d_zero) begin
            w_d_next   = r_d + ((w_x_d - w_y_d) <<< 2) + c_d_ten;
            // Kept one bit wider so r=0 steps to y=-1 and terminates
            w_y_next_s = signed'({1'b0, r_y}) - c_one_s;
        end else begin
            w_d_next   = r_d + (w_x_d <<< 2) + c_d_six;
            w_y_next_s = signed'({1'b0, r_y});
        end
        w_x_next   = w_x_next_s[RW:0];
        w_y_next   = w_y_next_s[RW:0];
        w_continue = (w_y_next_s >= w_x_next_s);
    end

    // -------------------------------------------- next slot to be presented
    logic [2:0]    w_ld_oct;
    logic [RW:0]   w_ld_x;
    logic [RW:0]   w_ld_y;
    logic [XW-1:0] w_ld_cx;
    logic [YW-1:0] w_ld_cy;

    always_comb begin
        w_ld_oct = r_oct + 3'd1;
        w_ld_x   = r_x;
        w_ld_y   = r_y;
        w_ld_cx  = r_cx;
        w_ld_cy  = r_cy;
        if (r_state == c_st_idle) begin
            w_ld_oct = 3'd0;
            w_ld_x   = '0;
            w_ld_y   = {1'b0, bus.r};
            w_ld_cx  = bus.cx;
            w_ld_cy  = bus.cy;
        end else if (r_state == c_st_step) begin
            w_ld_oct = 3'd0;
            w_ld_x   = w_x_next;
            w_ld_y   = w_y_next;
        end
    end

    logic signed [XW+1:0] w_cx_s;
    logic signed [XW+1:0] w_ax;
    logic signed [XW+1:0] w_ay;
    logic signed [XW+1:0] w_px;
    logic signed [YW+1:0] w_cy_s;
    logic signed [YW+1:0] w_bx;
    logic signed [YW+1:0] w_by;
    logic signed [YW+1:0] w_py;
    logic                 w_vis;

    always_comb begin
        w_cx_s = signed'((XW+2)'(w_ld_cx));
        w_ax   = signed'((XW+2)'(w_ld_x));
        w_ay   = signed'((XW+2)'(w_ld_y));
        w_cy_s = signed'((YW+2)'(w_ld_cy));
        w_bx   = signed'((YW+2)'(w_ld_x));
        w_by   = signed'((YW+2)'(w_ld_y));
        case (w_ld_oct)
            3'd0:    begin w_px = w_cx_s + w_ax; w_py = w_cy_s + w_by; end
            3'd1:    begin w_px = w_cx_s - w_ax; w_py = w_cy_s + w_by; end
            3'd2:    begin w_px = w_cx_s + w_ax; w_py = w_cy_s - w_by; end
            3'd3:    begin w_px = w_cx_s - w_ax; w_py = w_cy_s - w_by; end
            3'd4:    begin w_px = w_cx_s + w_ay; w_py = w_cy_s + w_bx; end
            3'd5:    begin w_px = w_cx_s - w_ay; w_py = w_cy_s + w_bx; end
            3'd6:    begin w_px = w_cx_s + w_ay; w_py = w_cy_s - w_bx; end
            default: begin w_px = w_cx_s - w_ay; w_py = w_cy_s - w_bx; end
        endcase
        w_vis = !w_px[XW+1] && (w_px < c_h_lim) && !w_py[YW+1] && (w_py < c_v_lim);
    end

    // A clipped slot (valid low) completes unconditionally after one cycle
    logic w_slot_done;
    assign w_slot_done = !r_pix_valid || bus.pix_ready;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cx        <= '0;
            r_cy        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_d         <= '0;
            r_oct       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_cx        <= bus.cx;
                        r_cy        <= bus.cy;
                        r_x         <= '0;
                        r_y         <= {1'b0, bus.r};
                        r_d         <= w_d_init;
                        r_busy      <= 1'b1;
                        r_state     <= c_st_plot;
                        r_oct       <= w_ld_oct;
                        r_pix_valid <= w_vis;
                        if (w_vis) begin
                            r_pix_x <= w_px[XW-1:0];
                            r_pix_y <= w_py[YW-1:0];
                        end
                    end
                end
                c_st_plot: begin
                    if (w_slot_done) begin
                        if (r_oct == 3'd7) begin
                            r_state     <= c_st_step;
                            r_pix_valid <= 1'b0;
                        end else begin
                            r_oct       <= w_ld_oct;
                            r_pix_valid <= w_vis;
                            if (w_vis) begin
                                r_pix_x <= w_px[XW-1:0];
                                r_pix_y <= w_py[YW-1:0];
                            end
                        end
                    end
                end
                c_st_step: begin
                    r_d <= w_d_next;
                    r_x <= w_x_next;
                    r_y <= w_y_next;
                    if (w_continue) begin
                        r_state     <= c_st_plot;
                        r_oct       <= w_ld_oct;
                        r_pix_valid <= w_vis;
                        if (w_vis) begin
                            r_pix_x <= w_px[XW-1:0];
                            r_pix_y <= w_py[YW-1:0];
                        end
                    end else begin
                        r_state <= c_st_done;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_x     = r_pix_x;
    assign bus.pix_y     = r_pix_y;

endmodule
`default_nettype wire

// File: tb/tb_circle_rasterizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_circle_rasterizer
// Purpose  : Self-checking bench for circle_rasterizer against a plain
//            integer midpoint-circle reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_circle_rasterizer;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int XW    = 10;
    localparam int YW    = 9;
    localparam int RW    = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    circle_rasterizer_if #(.XW(XW), .YW(YW), .RW(RW)) bus ();

    circle_rasterizer #(
        .H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW), .RW(RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int exp_x[$];
    int exp_y[$];
    int exp_iters;
    int got_x[$];
    int got_y[$];
    int done_cyc;
    int first_v;

    typedef struct {
        int cx;
        int cy;
        int r;
        int exp_vis;
        int exp_iters;
        int exp_first_v;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: every on-screen point in emission order, plus iteration count
    function automatic void build_model(input int cx, input int cy, input int r);
        int x = 0;
        int y = r;
        int d = 3 - 2 * r;
        exp_x.delete();
        exp_y.delete();
        exp_iters = 0;
        while (y >= x) begin
            for (int s = 0; s < 8; s++) begin
                int a  = (s < 4) ? x : y;
                int b  = (s < 4) ? y : x;
                int px = cx + (((s % 2) == 1) ? -a : a);
                int py = cy + (((s % 4) >= 2) ? -b : b);
                if (px >= 0 && px < H_RES && py >= 0 && py < V_RES) begin
                    exp_x.push_back(px);
                    exp_y.push_back(py);
                end
            end
            if (d > 0) begin
                d += 4 * (x - y) + 10;
                y--;
            end else begin
                d += 4 * x + 6;
            end
            x++;
            exp_iters++;
        end
    endfunction

    task automatic run_circle(input int cx, input int cy, input int r, input int ready_pct,
                              input int stall_after, input bit poke_start);
        int idx   = 0;
        int stall = 0;
        bit pv    = 1'b0;
        bit prdy  = 1'b0;
        int ppx   = 0;
        int ppy   = 0;
        bit seen_done = 1'b0;
        int v, x, y, bsy, dn;
        bit rdy;
        build_model(cx, cy, r);
        got_x.delete();
        got_y.delete();
        done_cyc = -1;
        first_v  = -1;
        @(negedge clk);
        bus.cx        = XW'(cx);
        bus.cy        = YW'(cy);
        bus.r         = RW'(r);
        bus.start     = 1'b1;
        bus.pix_ready = 1'b0;
        for (int cyc = 1; cyc <= 6000 && !seen_done; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (poke_start && cyc == 5) begin
                bus.start = 1'b1;
                bus.cx    = '0;
                bus.cy    = '0;
                bus.r     = RW'(7);
            end
            v   = int'(bus.pix_valid);
            x   = int'(bus.pix_x);
            y   = int'(bus.pix_y);
            bsy = int'(bus.busy);
            dn  = int'(bus.done);
            if (dn != 0) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                check("busy_at_done", bsy, 0);
                check("valid_at_done", v, 0);
            end else begin
                check("busy_while_running", bsy, 1);
                if (pv && !prdy) begin
                    check("hold_valid", v, 1);
                    check("hold_x", x, ppx);
                    check("hold_y", y, ppy);
                end
                if (stall > 0) begin
                    rdy = 1'b0;
                    stall--;
                end else begin
                    rdy = ($urandom_range(0, 99) < ready_pct);
                end
                bus.pix_ready = rdy;
                if (v != 0 && first_v < 0) first_v = cyc;
                if (v != 0 && rdy) begin
                    if (idx < exp_x.size()) begin
                        check("pix_x", x, exp_x[idx]);
                        check("pix_y", y, exp_y[idx]);
                    end else begin
                        check("extra_pixel", idx, exp_x.size());
                    end
                    got_x.push_back(x);
                    got_y.push_back(y);
                    idx++;
                    if (idx == stall_after) stall = 4;
                end
                pv   = (v != 0);
                prdy = rdy;
                ppx  = x;
                ppy  = y;
            end
        end
        check("done_seen", int'(seen_done), 1);
        check("pixel_count_vs_model", idx, exp_x.size());
        bus.pix_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", int'(bus.done), 0);
        check("busy_after_done", int'(bus.busy), 0);
        check("valid_after_done", int'(bus.pix_valid), 0);
        if (poke_start) begin
            repeat (3) @(negedge clk);
            check("start_not_queued", int'(bus.busy), 0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1_x[8] = '{320, 320, 320, 320, 321, 319, 321, 319};
        int r1_y[8] = '{241, 241, 239, 239, 240, 240, 240, 240};
        int dn_cnt;

        vecs[0] = '{320, 240, 0, 8, 1, 1};
        vecs[1] = '{320, 240, 1, 8, 1, 1};
        vecs[2] = '{100, 100, 3, 24, 3, 1};
        vecs[3] = '{0, 0, 5, 10, 4, 1};
        vecs[4] = '{639, 479, 2, 6, 2, 3};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cx        = '0;
        bus.cy        = '0;
        bus.r         = '0;
        bus.pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_valid", int'(bus.pix_valid), 0);
        check("reset_pix_x", int'(bus.pix_x), 0);
        check("reset_pix_y", int'(bus.pix_y), 0);
        rst = 1'b0;

        // Directed table with full-rate ready: exact pixel counts and timing
        for (int i = 0; i < 5; i++) begin
            run_circle(vecs[i].cx, vecs[i].cy, vecs[i].r, 100, -1, 1'b0);
            check("vec_pixel_count", got_x.size(), vecs[i].exp_vis);
            check("vec_done_cycle", done_cyc, 9 * vecs[i].exp_iters + 1);
            check("vec_first_valid", first_v, vecs[i].exp_first_v);
            if (i == 1) begin
                for (int k = 0; k < 8 && k < got_x.size(); k++) begin
                    check("r1_x", got_x[k], r1_x[k]);
                    check("r1_y", got_y[k], r1_y[k]);
                end
            end
            if (i == 3 && got_x.size() >= 4) begin
                check("edge_p0_y", got_y[0], 5);
                check("edge_p2_x", got_x[2], 5);
                check("edge_p3_y", got_y[3], 0);
            end
        end

        // Backpressure mid-stream plus an ignored start while busy
        run_circle(100, 100, 3, 100, 10, 1'b1);
        check("bp_pixel_count", got_x.size(), 24);
        check("bp_last_x", (got_x.size() == 24) ? got_x[23] : -1, 98);
        check("bp_last_y", (got_y.size() == 24) ? got_y[23] : -1, 98);

        // Reset during the second iteration
        @(negedge clk);
        bus.cx        = XW'(100);
        bus.cy        = YW'(100);
        bus.r         = RW'(3);
        bus.start     = 1'b1;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_reset_busy", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", int'(bus.pix_valid), 0);
        check("abort_busy", int'(bus.busy), 0);
        dn_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done) dn_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", dn_cnt, 0);
        run_circle(100, 100, 3, 100, -1, 1'b0);
        check("restart_pixel_count", got_x.size(), 24);
        check("restart_done_cycle", done_cyc, 28);
        check("restart_first_x", (got_x.size() > 0) ? got_x[0] : -1, 100);
        check("restart_first_y", (got_y.size() > 0) ? got_y[0] : -1, 103);

        // Randomized circles with random ready against the reference
        for (int t = 0; t < 8; t++) begin
            int rcx = int'($urandom_range(0, 700));
            int rcy = int'($urandom_range(0, 511));
            int rr  = int'($urandom_range(0, 25));
            int sa  = int'($urandom_range(1, 12));
            run_circle(rcx, rcy, rr, 65, sa, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
